// File: rtl/addr_dec_resp_mux_rob_if.sv
// Master-side TCDM port of addr_dec_resp_mux_rob.
//   req_i / add_i / wen_i / data_i : request from the master
//   gnt_o                          : grant back to the master
//   vld_o / rdata_o                : in-order response to the master
// Signal names are written from the decoder's point of view, so the
// "slave" modport is the one the decoder itself uses.
interface addr_dec_resp_mux_rob_if #(
    parameter int unsigned NumOut        = 32,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32
);
    localparam int unsigned AddrWidth = $clog2(NumOut);

    logic                     req_i;
    logic [AddrWidth-1:0]     add_i;
    logic                     wen_i;
    logic [ReqDataWidth-1:0]  data_i;
    logic                     gnt_o;
    logic                     vld_o;
    logic [RespDataWidth-1:0] rdata_o;

    modport master (
        output req_i, add_i, wen_i, data_i,
        input  gnt_o, vld_o, rdata_o
    );

    modport slave (
        input  req_i, add_i, wen_i, data_i,
        output gnt_o, vld_o, rdata_o
    );
endinterface

// File: rtl/addr_dec_resp_mux_rob.sv
// Per-master address decoder and in-order response path for a TCDM
// interconnect whose banks answer with variable latency.
// Granted requests are tracked in a reorder buffer (ROB) of MaxOutstanding
// entries; per-bank responses fill the oldest matching entry and the head
// entry is returned to the master as soon as it is filled.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   mst           : master port (request, grant, in-order response)
//   req_o, gnt_i  : decoded one-hot request / grants from the slaves
//   data_o        : request payload replicated to every slave port
//   rvalid_i      : per-bank response valid (reads and writes)
//   rdata_i       : per-bank response data
// NumOut must be >= 2 and MaxOutstanding >= 1.
module addr_dec_resp_mux_rob #(
    parameter int unsigned NumOut         = 32,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          WriteRespOn    = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    addr_dec_resp_mux_rob_if.slave          mst,
    output logic [NumOut-1:0]               req_o,
    input  logic [NumOut-1:0]               gnt_i,
    output logic [NumOut*ReqDataWidth-1:0]  data_o,
    input  logic [NumOut-1:0]               rvalid_i,
    input  logic [NumOut*RespDataWidth-1:0] rdata_i
);
    localparam int unsigned AddrWidth = $clog2(NumOut);
    localparam int unsigned PtrWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

    logic [MaxOutstanding-1:0] r_valid;
    logic [MaxOutstanding-1:0] r_filled;
    logic [MaxOutstanding-1:0] r_wen;
    logic [AddrWidth-1:0]      r_bank [MaxOutstanding];
    logic [RespDataWidth-1:0]  r_data [MaxOutstanding];
    logic [PtrWidth-1:0]       r_head;
    logic [PtrWidth-1:0]       r_tail;
    logic [CntWidth-1:0]       r_count;

    logic                      w_full;
    logic                      w_gnt;
    logic                      w_retire;
    logic                      w_vld;
    logic [MaxOutstanding-1:0] w_fill;
    logic [RespDataWidth-1:0]  w_fill_data [MaxOutstanding];
    logic [NumOut-1:0]         w_matched;
    logic [PtrWidth-1:0]       w_idx;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Position 'k' entries after 'p' in the circular buffer.
    function automatic logic [PtrWidth-1:0] ptr_add(input logic [PtrWidth-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= int'(MaxOutstanding)) s = s - int'(MaxOutstanding);
        return PtrWidth'(s);
    endfunction

    // Decode and grant. Full is taken from the registered count only, so a
    // retire frees its slot for the following cycle, never the same one.
    assign w_full = (r_count == CntWidth'(MaxOutstanding));
    assign w_gnt  = mst.req_i & ~w_full & gnt_i[mst.add_i];

    always_comb begin
        req_o            = '0;
        req_o[mst.add_i] = mst.req_i & ~w_full;
    end

    assign mst.gnt_o = w_gnt;
    assign data_o    = {NumOut{mst.data_i}};

    // Each bank fills the oldest valid, unfilled entry that targets it.
    // Banks answer in order, so that entry is always the right one; entries
    // allocated this cycle are not yet valid and therefore cannot match.
    always_comb begin
        w_fill    = '0;
        w_matched = '0;
        w_idx     = '0;
        for (int e = 0; e < int'(MaxOutstanding); e++) w_fill_data[e] = '0;
        for (int b = 0; b < int'(NumOut); b++) begin
            for (int k = 0; k < int'(MaxOutstanding); k++) begin
                w_idx = ptr_add(r_head, k);
                if (rvalid_i[b] && !w_matched[b] && r_valid[w_idx] && !r_filled[w_idx] &&
                    (r_bank[w_idx] == AddrWidth'(b))) begin
                    w_fill[w_idx]      = 1'b1;
                    w_fill_data[w_idx] = rdata_i[b*RespDataWidth +: RespDataWidth];
                    w_matched[b]       = 1'b1;
                end
            end
        end
    end

    // A filled head retires every time; write retirements are only shown to
    // the master when WriteRespOn is set.
    assign w_retire    = r_valid[r_head] & r_filled[r_head];
    assign w_vld       = w_retire & (~r_wen[r_head] | WriteRespOn);
    assign mst.vld_o   = w_vld;
    assign mst.rdata_o = w_vld ? r_data[r_head] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid  <= '0;
            r_filled <= '0;
            r_wen    <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            for (int e = 0; e < int'(MaxOutstanding); e++) begin
                r_bank[e] <= '0;
                r_data[e] <= '0;
            end
        end else begin
            for (int e = 0; e < int'(MaxOutstanding); e++) begin
                if (w_fill[e]) begin
                    r_filled[e] <= 1'b1;
                    r_data[e]   <= w_fill_data[e];
                end
            end
            if (w_retire) begin
                r_valid[r_head]  <= 1'b0;
                r_filled[r_head] <= 1'b0;
                r_head           <= ptr_inc(r_head);
            end
            // tail == head with a retire only happens when full, where no
            // grant is possible, so these writes never collide.
            if (w_gnt) begin
                r_valid[r_tail]  <= 1'b1;
                r_filled[r_tail] <= 1'b0;
                r_wen[r_tail]    <= mst.wen_i;
                r_bank[r_tail]   <= mst.add_i;
                r_tail           <= ptr_inc(r_tail);
            end
            case ({w_gnt, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A response with no outstanding request is dropped (e.g. after a reset).
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ((rvalid_i & ~w_matched) == '0)
                else $warning("rvalid_i without outstanding request dropped: %h", rvalid_i & ~w_matched);
        end
    end
endmodule

// File: tb/tb_addr_dec_resp_mux_rob.sv
`timescale 1ns/1ps
module tb_addr_dec_resp_mux_rob;
    localparam int NO = 32;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int MO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            req = 1'b0;
    logic [4:0]      add = '0;
    logic            wen = 1'b0;
    logic [DW-1:0]   data = '0;
    logic [NO-1:0]   gnt_in = '1;
    logic [NO-1:0]   rvalid = '0;
    logic [NO*RW-1:0] rdata_bus = '0;

    logic [NO-1:0]    req_o1, req_o0;
    logic [NO*DW-1:0] data_o1, data_o0;

    addr_dec_resp_mux_rob_if #(.NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(RW)) mif1 ();
    addr_dec_resp_mux_rob_if #(.NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(RW)) mif0 ();

    assign mif1.req_i  = req;
    assign mif1.add_i  = add;
    assign mif1.wen_i  = wen;
    assign mif1.data_i = data;
    assign mif0.req_i  = req;
    assign mif0.add_i  = add;
    assign mif0.wen_i  = wen;
    assign mif0.data_i = data;

    addr_dec_resp_mux_rob #(.NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(RW),
                            .MaxOutstanding(MO), .WriteRespOn(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mst(mif1),
        .req_o(req_o1), .gnt_i(gnt_in), .data_o(data_o1),
        .rvalid_i(rvalid), .rdata_i(rdata_bus)
    );

    addr_dec_resp_mux_rob #(.NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(RW),
                            .MaxOutstanding(MO), .WriteRespOn(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mst(mif0),
        .req_o(req_o0), .gnt_i(gnt_in), .data_o(data_o0),
        .rvalid_i(rvalid), .rdata_i(rdata_bus)
    );

    // {req_o, gnt, vld, rdata} of the write-response DUT, then the silent-write DUT
    logic [131:0] obs, exp_obs;
    assign obs = {req_o1, mif1.gnt_o, mif1.vld_o, mif1.rdata_o,
                  req_o0, mif0.gnt_o, mif0.vld_o, mif0.rdata_o};

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding requests in grant order.
    typedef struct {
        int          bank;
        logic        wen;
        logic        filled;
        logic [31:0] data;
    } ent_t;
    ent_t rob[$];
    logic m_gnt;

    task automatic model_expect();
        logic [NO-1:0] er;
        logic eg, v1, v0;
        logic [31:0] hd;
        er = '0;
        eg = 1'b0;
        if (req && rob.size() < MO) begin
            er[add] = 1'b1;
            eg = gnt_in[add];
        end
        v1 = 1'b0;
        v0 = 1'b0;
        hd = '0;
        if (rob.size() > 0) begin
            if (rob[0].filled) begin
                v1 = 1'b1;
                v0 = !rob[0].wen;
                hd = rob[0].data;
            end
        end
        m_gnt   = eg;
        exp_obs = {er, eg, v1, v1 ? hd : 32'h0, er, eg, v0, v0 ? hd : 32'h0};
    endtask

    task automatic tick();
        bit   ret;
        ent_t ne;
        @(posedge clk);
        model_expect();
        ret = (rob.size() > 0) && rob[0].filled;
        for (int b = 0; b < NO; b++) begin
            if (rvalid[b]) begin
                for (int i = 0; i < rob.size(); i++) begin
                    if (rob[i].bank == b && !rob[i].filled) begin
                        rob[i].filled = 1'b1;
                        rob[i].data   = rdata_bus[b*RW +: RW];
                        break;
                    end
                end
            end
        end
        if (ret) void'(rob.pop_front());
        if (m_gnt) begin
            ne.bank = int'(add);
            ne.wen = wen;
            ne.filled = 1'b0;
            ne.data = '0;
            rob.push_back(ne);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = 1'b0;
        wen    = 1'b0;
        add    = '0;
        data   = '0;
        rvalid = '0;
        gnt_in = '1;
        rob.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic r, input int a, input logic w, input logic [31:0] d);
        req  = r;
        add  = 5'(a);
        wen  = w;
        data = d;
    endtask

    task automatic drive_rsp(input int b, input logic [31:0] d);
        rvalid[b] = 1'b1;
        rdata_bus[b*RW +: RW] = d;
    endtask

    task automatic test_reset();
        logic [NO*DW-1:0] exp_d;
        do_reset();
        model_expect();
        @(negedge clk);
        n_checks++;
        if ({req_o1, mif1.gnt_o, mif1.vld_o, mif1.rdata_o} !== {32'h0, 1'b0, 1'b0, 32'h0}) begin
            n_errors++;
            $display("FAIL reset_outputs got %h exp 0", {req_o1, mif1.gnt_o, mif1.vld_o, mif1.rdata_o});
        end
        n_checks++;
        if (u_dut1.r_count !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_count got %0d exp 0", u_dut1.r_count);
        end
        tick();
        // gnt_i on a bank that is not being requested must be ignored
        drive_req(1'b1, 9, 1'b0, $urandom());
        gnt_in = 32'h0000_0400;
        for (int i = 0; i < NO; i++) exp_d[i*DW +: DW] = data;
        model_expect();
        @(negedge clk);
        n_checks++;
        if ({req_o1, mif1.gnt_o} !== {32'h0000_0200, 1'b0}) begin
            n_errors++;
            $display("FAIL decode_ignore_gnt got %h/%b exp 00000200/0", req_o1, mif1.gnt_o);
        end
        n_checks++;
        if (data_o1 !== exp_d) begin
            n_errors++;
            $display("FAIL data_bcast got %h exp %h", data_o1[63:0], exp_d[63:0]);
        end
        n_checks++;
        if (obs !== exp_obs) begin
            n_errors++;
            $display("FAIL reset_model got %h exp %h", obs, exp_obs);
        end
        tick();
        gnt_in = '1;
        req = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            rvalid = '0;
            drive_req(c == 0, 3, 1'b0, 32'h1234);
            if (c == 2) drive_rsp(3, 32'hDEADBEEF);
            model_expect();
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin
                n_errors++;
                $display("FAIL single_read c=%0d got %h exp %h", c, obs, exp_obs);
            end
            if (c == 3) begin
                n_checks++;
                if ({mif1.vld_o, mif1.rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
                    n_errors++;
                    $display("FAIL single_read_data got %b/%h exp 1/deadbeef", mif1.vld_o, mif1.rdata_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_reorder();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rvalid = '0;
            drive_req(c < 2, (c == 0) ? 1 : 2, 1'b0, 32'h0);
            if (c == 2) drive_rsp(2, 32'h22);
            if (c == 4) drive_rsp(1, 32'h11);
            model_expect();
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin
                n_errors++;
                $display("FAIL reorder c=%0d got %h exp %h", c, obs, exp_obs);
            end
            if (c == 5 || c == 6) begin
                n_checks++;
                if ({mif1.vld_o, mif1.rdata_o} !== {1'b1, (c == 5) ? 32'h11 : 32'h22}) begin
                    n_errors++;
                    $display("FAIL reorder_order c=%0d got %b/%h", c, mif1.vld_o, mif1.rdata_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_same_bank();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            rvalid = '0;
            drive_req(c < 2, 5, 1'b0, 32'h0);
            if (c == 2) drive_rsp(5, 32'hA);
            if (c == 3) drive_rsp(5, 32'hB);
            model_expect();
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin
                n_errors++;
                $display("FAIL same_bank c=%0d got %h exp %h", c, obs, exp_obs);
            end
            if (c == 3 || c == 4) begin
                n_checks++;
                if ({mif1.vld_o, mif1.rdata_o} !== {1'b1, (c == 3) ? 32'hA : 32'hB}) begin
                    n_errors++;
                    $display("FAIL same_bank_order c=%0d got %b/%h", c, mif1.vld_o, mif1.rdata_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            rvalid = '0;
            drive_req(c < 7, 7, 1'b0, 32'h0);
            if (c == 4 || (c >= 7 && c <= 10)) drive_rsp(7, 32'h7000_0000 + 32'(c));
            model_expect();
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin
                n_errors++;
                $display("FAIL full c=%0d got %h exp %h", c, obs, exp_obs);
            end
            if (c == 4 || c == 5) begin
                n_checks++;
                if ({req_o1, mif1.gnt_o} !== {32'h0, 1'b0}) begin
                    n_errors++;
                    $display("FAIL full_block c=%0d got %h/%b exp 0/0", c, req_o1, mif1.gnt_o);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (mif1.gnt_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL full_regrant got %b exp 1", mif1.gnt_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_resp();
        int          pulses;
        logic [31:0] got;
        do_reset();
        pulses = 0;
        got = '0;
        for (int c = 0; c < 8; c++) begin
            rvalid = '0;
            drive_req(c < 2, 0, c == 0, 32'hCAFE);
            if (c == 2) drive_rsp(0, 32'h77);
            if (c == 3) drive_rsp(0, 32'h55);
            model_expect();
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin
                n_errors++;
                $display("FAIL write_resp c=%0d got %h exp %h", c, obs, exp_obs);
            end
            if (mif0.vld_o === 1'b1) begin
                pulses++;
                got = mif0.rdata_o;
            end
            tick();
        end
        n_checks++;
        if (pulses != 1 || got !== 32'h55) begin
            n_errors++;
            $display("FAIL write_silent pulses=%0d data=%h exp 1/00000055", pulses, got);
        end
        n_checks++;
        if (u_dut0.r_count !== 3'd0) begin
            n_errors++;
            $display("FAIL write_count got %0d exp 0", u_dut0.r_count);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            rvalid = '0;
            drive_req(c < 2, (c == 0) ? 4 : 6, 1'b0, 32'h0);
            tick();
        end
        n_checks++;
        if (u_dut1.r_count !== 3'd2) begin
            n_errors++;
            $display("FAIL midop_outstanding got %0d exp 2", u_dut1.r_count);
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            rvalid = '0;
            if (c == 0) begin
                drive_rsp(4, 32'h44);
                drive_rsp(6, 32'h66);
            end
            model_expect();
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs || mif1.vld_o !== 1'b0 || mif0.vld_o !== 1'b0) begin
                n_errors++;
                $display("FAIL midop_drop c=%0d got %h exp %h", c, obs, exp_obs);
            end
            tick();
        end
        n_checks++;
        if ({u_dut1.r_count, u_dut1.r_valid} !== 7'd0) begin
            n_errors++;
            $display("FAIL midop_empty got count=%0d valid=%b exp 0/0", u_dut1.r_count, u_dut1.r_valid);
        end
    endtask

    task automatic test_random();
        bit pending;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rvalid = '0;
            if (c < 440) begin
                drive_req($urandom_range(0, 9) < 7, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom());
                gnt_in = $urandom() | $urandom();
            end else begin
                drive_req(1'b0, 0, 1'b0, 32'h0);
            end
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 1) == 1 || c >= 440) begin
                    pending = 1'b0;
                    foreach (rob[i]) if (rob[i].bank == b && !rob[i].filled) pending = 1'b1;
                    if (pending) drive_rsp(b, $urandom());
                end
            end
            model_expect();
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin
                n_errors++;
                $display("FAIL random c=%0d got %h exp %h", c, obs, exp_obs);
            end
            n_checks++;
            if (u_dut1.r_count !== 3'(rob.size())) begin
                n_errors++;
                $display("FAIL random_count c=%0d got %0d exp %0d", c, u_dut1.r_count, rob.size());
            end
            tick();
        end
        gnt_in = '1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reorder();
        test_same_bank();
        test_full();
        test_write_resp();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
